// File: rtl/vx_dispatch_router_if.sv
// Dispatch-side and execute-lane-side signal bundle for vx_dispatch_router.
// master drives dispatch packets and lane ready; slave is the router.
interface vx_dispatch_router_if #(
  parameter int NUM_EX  = 4,
  parameter int EX_BITS = 2,
  parameter int DATAW   = 128,
  parameter int PERF_W  = 32
);
  logic                    in_valid;
  logic [EX_BITS-1:0]      in_ex_type;
  logic [DATAW-1:0]        in_data;
  logic                    in_ready;
  logic [NUM_EX-1:0]       out_valid;
  logic [NUM_EX*DATAW-1:0] out_data;
  logic [NUM_EX-1:0]       out_ready;
  logic                    err_bad_ex;
  logic [PERF_W-1:0]       perf_stalls;

  modport master (
    output in_valid, in_ex_type, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_bad_ex, perf_stalls
  );

  modport slave (
    input  in_valid, in_ex_type, in_data, out_ready,
    output in_ready, out_valid, out_data, err_bad_ex, perf_stalls
  );
endinterface

// File: rtl/vx_dispatch_router.sv
// Routes the dispatch stream to NUM_EX execute lanes by ex_type, each lane
// behind its own 2-entry registered FIFO so one stalled unit never blocks others.
module vx_dispatch_router #(
  parameter int NUM_EX  = 4,
  parameter int EX_BITS = 2,
  parameter int DATAW   = 128,
  parameter int PERF_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_dispatch_router_if.slave  io
);
  logic [NUM_EX-1:0] lane_sel;
  logic [NUM_EX-1:0] lane_full;
  logic              ex_legal;
  logic              in_ready;
  logic              accept;

  logic              err_q, err_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  // in_ready looks only at lane occupancy, never at out_ready, so a full lane
  // refuses even when it is popping this cycle.
  assign ex_legal    = |lane_sel;
  assign in_ready    = ~|(lane_sel & lane_full);
  assign accept      = io.in_valid & in_ready;
  assign io.in_ready = in_ready;

  for (genvar i = 0; i < NUM_EX; i++) begin : g_lane
    logic [DATAW-1:0] mem_q [2];
    logic [DATAW-1:0] mem_d [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign lane_sel[i]  = (io.in_ex_type == EX_BITS'(i));
    assign lane_full[i] = (count_q == 2'd2);
    assign push         = accept & lane_sel[i];
    assign pop          = io.out_valid[i] & io.out_ready[i];

    always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
        mem_d[tail_q] = io.in_data;
        tail_d        = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        head_q  <= 1'b0;
        tail_q  <= 1'b0;
        count_q <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
      end
    end

    // Payload storage carries no reset; it is only observed while count_q != 0.
    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end

    assign io.out_valid[i]               = (count_q != 2'd0);
    assign io.out_data[i*DATAW +: DATAW] = mem_q[head_q];
  end

  always_comb begin
    err_d  = err_q | (accept & ~ex_legal);
    perf_d = perf_q;
    if (io.in_valid && !in_ready && perf_q != '1) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q  <= 1'b0;
      perf_q <= '0;
    end else begin
      err_q  <= err_d;
      perf_q <= perf_d;
    end
  end

  assign io.err_bad_ex  = err_q;
  assign io.perf_stalls = perf_q;
endmodule

// File: tb/tb_vx_dispatch_router.sv
// Bench for vx_dispatch_router: a 4-lane/32-bit-counter instance and a
// 3-lane/3-bit-counter instance share stimulus and are checked against a queue model.
module tb_vx_dispatch_router;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_dispatch_router_if #(.NUM_EX(4), .EX_BITS(2), .DATAW(128), .PERF_W(32)) bus4 ();
  vx_dispatch_router_if #(.NUM_EX(3), .EX_BITS(2), .DATAW(128), .PERF_W(3))  bus3 ();

  vx_dispatch_router #(.NUM_EX(4), .EX_BITS(2), .DATAW(128), .PERF_W(32)) dut4 (
    .clk(clk), .reset(reset), .io(bus4)
  );
  vx_dispatch_router #(.NUM_EX(3), .EX_BITS(2), .DATAW(128), .PERF_W(3)) dut3 (
    .clk(clk), .reset(reset), .io(bus3)
  );

  assign bus3.in_valid   = bus4.in_valid;
  assign bus3.in_ex_type = bus4.in_ex_type;
  assign bus3.in_data    = bus4.in_data;
  assign bus3.out_ready  = bus4.out_ready[2:0];

  int n_chk  = 0;
  int n_fail = 0;

  localparam int          NEX  [2] = '{4, 3};
  localparam longint      PMAX [2] = '{64'hFFFF_FFFF, 64'd7};
  logic [127:0]           mq   [2][4][$];
  longint                 mperf[2];
  bit                     merr [2];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready(int d);
    int ex = int'(bus4.in_ex_type);
    if (ex >= NEX[d]) return 1'b1;
    return mq[d][ex].size() < 2;
  endfunction

  // Reference: per-lane queues; pops use pre-edge occupancy, pushes follow pops.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) mq[d][i].delete();
        mperf[d] = 0;
        merr[d]  = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit rdy;
        int ex;
        rdy = model_ready(d);
        ex  = int'(bus4.in_ex_type);
        for (int i = 0; i < NEX[d]; i++)
          if (mq[d][i].size() > 0 && bus4.out_ready[i]) void'(mq[d][i].pop_front());
        if (bus4.in_valid) begin
          if (rdy) begin
            if (ex < NEX[d]) mq[d][ex].push_back(bus4.in_data);
            else merr[d] = 1'b1;
          end else if (mperf[d] < PMAX[d]) begin
            mperf[d]++;
          end
        end
      end
    end
  end

  task automatic cmp_dut(int d, logic ar, logic [3:0] av, logic [511:0] ad,
                         logic ae, logic [63:0] ap);
    check($sformatf("d%0d_in_ready", d), {127'b0, ar}, {127'b0, model_ready(d)});
    for (int i = 0; i < NEX[d]; i++) begin
      check($sformatf("d%0d_out_valid%0d", d, i), {127'b0, av[i]},
            {127'b0, mq[d][i].size() != 0});
      if (mq[d][i].size() != 0)
        check($sformatf("d%0d_out_data%0d", d, i), ad[i*128 +: 128], mq[d][i][0]);
    end
    check($sformatf("d%0d_err_bad_ex", d), {127'b0, ae}, {127'b0, merr[d]});
    check($sformatf("d%0d_perf_stalls", d), {64'b0, ap}, {64'b0, mperf[d]});
  endtask

  always @(negedge clk) begin
    cmp_dut(0, bus4.in_ready, bus4.out_valid, bus4.out_data,
            bus4.err_bad_ex, {32'b0, bus4.perf_stalls});
    cmp_dut(1, bus3.in_ready, {1'b0, bus3.out_valid}, {128'b0, bus3.out_data},
            bus3.err_bad_ex, {61'b0, bus3.perf_stalls});
  end

  task automatic drive(logic v, logic [1:0] ex, logic [127:0] data, logic [3:0] ordy);
    bus4.in_valid   = v;
    bus4.in_ex_type = ex;
    bus4.in_data    = data;
    bus4.out_ready  = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] lane4(int i);
    return bus4.out_data[i*128 +: 128];
  endfunction

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, '0, 4'b0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {127'b0, bus4.in_ready}, 128'd1);
    check("post_reset_valid", {124'b0, bus4.out_valid}, 128'd0);

    // single packet to lane 2
    step(); drive(1'b1, 2'd2, 128'hA5, 4'b0000);
    step(); drive(1'b0, 2'd2, 128'h0, 4'b0100);
    @(negedge clk);
    check("single_valid", {124'b0, bus4.out_valid}, 128'h4);
    check("single_data", lane4(2), 128'hA5);
    step(); drive(1'b0, 2'd2, 128'h0, 4'b0000);
    @(negedge clk);
    check("single_drained", {124'b0, bus4.out_valid}, 128'h0);

    // fill lane 1 and back-pressure
    step(); drive(1'b1, 2'd1, 128'h1, 4'b0000);
    step(); drive(1'b1, 2'd1, 128'h2, 4'b0000);
    @(negedge clk);
    check("fill_ready_cnt1", {127'b0, bus4.in_ready}, 128'd1);
    step(); drive(1'b1, 2'd1, 128'h3, 4'b0000);
    @(negedge clk);
    check("fill_ready_full", {127'b0, bus4.in_ready}, 128'd0);
    check("fill_perf0", {96'b0, bus4.perf_stalls}, 128'd0);
    step();
    @(negedge clk);
    check("fill_perf1", {96'b0, bus4.perf_stalls}, 128'd1);
    check("fill_head", lane4(1), 128'h1);
    step(); drive(1'b1, 2'd1, 128'h3, 4'b0010);
    @(negedge clk);
    check("fill_no_bypass", {127'b0, bus4.in_ready}, 128'd0);
    check("fill_perf2", {96'b0, bus4.perf_stalls}, 128'd2);
    step();
    @(negedge clk);
    check("fill_pop1_data", lane4(1), 128'h2);
    check("fill_pop1_ready", {127'b0, bus4.in_ready}, 128'd1);
    check("fill_perf3", {96'b0, bus4.perf_stalls}, 128'd3);
    step(); drive(1'b0, 2'd1, 128'h0, 4'b0010);
    @(negedge clk);
    check("fill_pop2_data", lane4(1), 128'h3);
    step(); drive(1'b0, 2'd1, 128'h0, 4'b0000);
    @(negedge clk);
    check("fill_empty", {124'b0, bus4.out_valid}, 128'h0);

    // ex_type 3 is illegal for the 3-lane instance
    check("bad_err_before", {127'b0, bus3.err_bad_ex}, 128'd0);
    step(); drive(1'b1, 2'd3, 128'hBAD, 4'b0000);
    @(negedge clk);
    check("bad_ready", {127'b0, bus3.in_ready}, 128'd1);
    step(); drive(1'b0, 2'd0, 128'h0, 4'b1000);
    @(negedge clk);
    check("bad_err_set", {127'b0, bus3.err_bad_ex}, 128'd1);
    check("bad_no_valid", {125'b0, bus3.out_valid}, 128'd0);
    check("bad_lane3_on_4", {124'b0, bus4.out_valid}, 128'h8);
    step(); drive(1'b0, 2'd0, 128'h0, 4'b0000);
    repeat (3) step();
    @(negedge clk);
    check("bad_err_held", {127'b0, bus3.err_bad_ex}, 128'd1);

    // independence: lane 0 full, lane 3 still flows
    step(); drive(1'b1, 2'd0, 128'h20, 4'b0000);
    step(); drive(1'b1, 2'd0, 128'h21, 4'b0000);
    step(); drive(1'b1, 2'd3, 128'h30, 4'b0000);
    @(negedge clk);
    check("indep_ready", {127'b0, bus4.in_ready}, 128'd1);
    step(); drive(1'b0, 2'd0, 128'h0, 4'b1000);
    @(negedge clk);
    check("indep_valid", {124'b0, bus4.out_valid}, 128'h9);
    check("indep_lane3", lane4(3), 128'h30);
    step(); drive(1'b0, 2'd0, 128'h0, 4'b0001);
    @(negedge clk);
    check("indep_lane0_kept", lane4(0), 128'h20);
    step();
    @(negedge clk);
    check("indep_lane0_next", lane4(0), 128'h21);
    step(); drive(1'b0, 2'd0, 128'h0, 4'b0000);

    // simultaneous push/pop at count 1 on lane 2
    step(); drive(1'b1, 2'd2, 128'h10, 4'b0000);
    step(); drive(1'b1, 2'd2, 128'h11, 4'b0100);
    step(); drive(1'b0, 2'd2, 128'h0, 4'b0000);
    @(negedge clk);
    check("pp_valid", {124'b0, bus4.out_valid}, 128'h4);
    check("pp_data", lane4(2), 128'h11);
    step(); drive(1'b0, 2'd2, 128'h0, 4'b0100);
    step(); drive(1'b0, 2'd2, 128'h0, 4'b0000);

    // stall counter saturation on the 3-bit instance
    step(); drive(1'b1, 2'd1, 128'h40, 4'b0000);
    step(); drive(1'b1, 2'd1, 128'h41, 4'b0000);
    step(); drive(1'b1, 2'd1, 128'h42, 4'b0000);
    repeat (8) step();
    @(negedge clk);
    check("sat_perf3", {125'b0, bus3.perf_stalls}, 128'd7);
    check("sat_perf4", {96'b0, bus4.perf_stalls}, 128'd11);

    // asynchronous reset between edges with two lanes occupied
    step(); drive(1'b1, 2'd2, 128'h50, 4'b0000);
    step(); drive(1'b0, 2'd1, 128'h0, 4'b0000);
    @(negedge clk);
    check("pre_rst_valid", {124'b0, bus4.out_valid}, 128'h6);
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", {124'b0, bus4.out_valid}, 128'h0);
    check("rst_async_perf", {96'b0, bus4.perf_stalls}, 128'd0);
    check("rst_async_err", {127'b0, bus3.err_bad_ex}, 128'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {127'b0, bus4.in_ready}, 128'd1);
    step(); drive(1'b1, 2'd1, 128'h60, 4'b0000);
    step(); drive(1'b0, 2'd1, 128'h0, 4'b0010);
    @(negedge clk);
    check("rst_fresh_valid", {124'b0, bus4.out_valid}, 128'h2);
    check("rst_fresh_data", lane4(1), 128'h60);
    step(); drive(1'b0, 2'd1, 128'h0, 4'b0000);
    @(negedge clk);
    check("rst_fresh_drained", {124'b0, bus4.out_valid}, 128'h0);

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_dispatch_router.md
Name: vx_dispatch_router

Overview:
- Sits directly downstream of the issue/dispatch stage. Consumes the single dispatch stream: valid/ready plus decoded instruction payload and ex_type.
- Routes each instruction to one of NUM_EX execute-unit lanes (ALU, LSU, CSR, FPU, ...) by ex_type.
- Each lane has a registered 2-entry elastic buffer. A stall in one unit does not corrupt order in the other units. A stall only blocks the dispatch head when that head targets the stalled unit.

Parameters:
- NUM_EX, 4, number of execute-unit output lanes; legal 1..(2^EX_BITS).
- EX_BITS, 2, width of ex_type selector.
- DATAW, 128, packed payload width: uuid, wid, tmask, PC, op_type, op_mod, wb, use_PC, use_imm, imm, rd. The packing order is fixed by the producer.
- PERF_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  dispatch packet valid.
- in_ex_type  in  EX_BITS  target execute unit index.
- in_data  in  DATAW  packed dispatch payload.
- in_ready  out  1  router accepts packet this cycle.
- out_valid  out  NUM_EX  per-lane packet valid.
- out_data  out  NUM_EX*DATAW  per-lane payload; lane i at [i*DATAW +: DATAW].
- out_ready  in  NUM_EX  per-lane consumer ready.
- err_bad_ex  out  1  sticky: a packet with ex_type >= NUM_EX was accepted.
- perf_stalls  out  PERF_W  count of cycles with in_valid && !in_ready.

Behaviour:
- Handshake:
  - Transfer occurs on in_valid && in_ready at the rising edge.
  - Lane i pops on out_valid[i] && out_ready[i].
  - in_valid and in_data must stay stable while in_ready is low. The router does not check this.
- in_ready, combinational from in_ex_type and lane state:
  - If in_ex_type < NUM_EX: in_ready = (count[in_ex_type] != 2). A full lane refuses even if it pops the same cycle; there is no full-lane bypass.
  - If in_ex_type >= NUM_EX: in_ready = 1.
  - There is no combinational path from out_ready to in_ready.
- Per-lane buffer:
  - 2-entry FIFO with head/tail pointers (1 bit each) and count (0..2).
  - out_valid[i] = (count[i] != 0). out_data[i] = entry at the head, straight from flops.
  - Latency: a packet accepted in cycle N is visible on out_valid at N+1 at the earliest.
  - Push and pop in the same cycle at count 1: count stays 1, pointers both advance, data order is preserved.
  - Push when count 0: written entry becomes head next cycle.
  - Pointers wrap 1 -> 0.
- Ordering:
  - Strict FIFO within a lane.
  - No ordering guarantee across lanes; units are independent.
- Bad ex_type (>= NUM_EX):
  - Packet is accepted and discarded, and no lane is written.
  - err_bad_ex sets on the next edge and holds until reset.
- perf_stalls:
  - Increments by 1 on each edge where in_valid && !in_ready.
  - Saturates at 2^PERF_W-1 with no wrap.
- Reset, asynchronous, active-high, at any time including mid-transfer:
  - All counts and pointers go to 0, so out_valid = 0.
  - err_bad_ex = 0 and perf_stalls = 0.
  - Buffer data contents are don't-care, and out_data is don't-care while out_valid = 0.
  - Packets in flight are lost. Upstream re-dispatch is the upstream's responsibility.
  - After reset deasserts, in_ready for a legal ex_type is 1 in the first cycle.
- No state machine beyond the per-lane FIFO counters. Lanes are identical generate instances.

Test Plan:
- Single packet: reset, in_valid=1, ex_type=2, data=0xA5 for one cycle -> out_valid=4'b0100 next cycle with out_data lane2=0xA5; after out_ready[2]=1 for one cycle, out_valid returns to 0.
- Lane fill/back-pressure: out_ready=0, push 3 packets (0x1, 0x2, 0x3) to lane 1 on consecutive cycles:
  - in_ready=0 on the third cycle, and perf_stalls increments each stalled cycle.
  - Raise out_ready[1] -> pops 0x1, then 0x2; the third push is accepted the cycle after the first pop. Output order is 0x1, 0x2, 0x3.
- Independence: lane 0 full and stalled, push to lane 3 -> in_ready=1 and lane 3 delivers. Lane 0 contents stay unchanged.
- Simultaneous push/pop at count 1: lane 2 holds 0x10, out_ready[2]=1, push 0x11 same cycle -> count stays 1, next out_data lane2=0x11.
- Bad ex_type with NUM_EX=3: push with ex_type=3 -> in_ready=1, no out_valid asserts, err_bad_ex=1 from next cycle and held.
- Async reset mid-operation: two lanes holding packets, assert reset between clock edges -> out_valid=0 and perf_stalls=0 immediately without a clock edge. After release, a fresh push delivers normally.
